// File: rtl/muldiv_seq.sv
// Sequential M-extension unit: multi-cycle multiply and radix-2 restoring divide
// behind a single-entry valid/ready request/result handshake.
module muldiv_seq #(
   parameter int XLEN       = 32,
   parameter int MUL_CYCLES = 2
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_op_a,
   input  logic [XLEN-1:0] i_op_b,
   input  logic            i_flush,
   output logic            o_res_valid,
   input  logic            i_res_ready,
   output logic [XLEN-1:0] o_result,
   output logic            o_busy
);

   localparam int CW = $clog2(XLEN + 1);
   localparam int PW = 2 * XLEN + 2;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t          r_state, w_state_nxt;
   logic [XLEN-1:0] r_a, r_b, r_quo, r_rem, r_result;
   logic [2:0]      r_f3;
   logic [CW-1:0]   r_cnt;

   // request decode and divide bypass detection on the incoming operands
   logic            w_is_m, w_accept, w_in_sgn, w_div0, w_ovf, w_bypass;
   logic [2:0]      w_in_f3;
   logic [XLEN-1:0] w_byp_res, w_a_mag_in;

   assign w_is_m     = (i_instr[6:0] == 7'b0110011) && (i_instr[31:25] == 7'b0000001);
   assign w_accept   = i_req_valid && (r_state == S_IDLE) && !i_flush && w_is_m;
   assign w_in_f3    = i_instr[14:12];
   assign w_in_sgn   = ~w_in_f3[0];
   assign w_div0     = (i_op_b == '0);
   assign w_ovf      = w_in_sgn && (i_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (i_op_b == '1);
   assign w_bypass   = w_in_f3[2] && (w_div0 || w_ovf);
   assign w_byp_res  = w_div0 ? (w_in_f3[1] ? i_op_a : '1) : (w_in_f3[1] ? '0 : i_op_a);
   assign w_a_mag_in = (w_in_sgn && i_op_a[XLEN-1]) ? -i_op_a : i_op_a;

   // divide iteration on magnitudes; quotient bits shift in where dividend bits shift out
   logic            w_sgn, w_ge;
   logic [XLEN-1:0] w_b_mag, w_quo_nxt, w_q_fin, w_r_fin, w_div_res;
   logic [XLEN:0]   w_shift, w_diff, w_rem_nxt;

   assign w_sgn     = ~r_f3[0];
   assign w_b_mag   = (w_sgn && r_b[XLEN-1]) ? -r_b : r_b;
   assign w_shift   = {r_rem, r_quo[XLEN-1]};
   assign w_diff    = w_shift - {1'b0, w_b_mag};
   assign w_ge      = ~w_diff[XLEN];
   assign w_rem_nxt = w_ge ? w_diff : w_shift;
   assign w_quo_nxt = {r_quo[XLEN-2:0], w_ge};
   assign w_q_fin   = (w_sgn && (r_a[XLEN-1] ^ r_b[XLEN-1])) ? -w_quo_nxt : w_quo_nxt;
   assign w_r_fin   = (w_sgn && r_a[XLEN-1]) ? -w_rem_nxt[XLEN-1:0] : w_rem_nxt[XLEN-1:0];
   assign w_div_res = r_f3[1] ? w_r_fin : w_q_fin;

   // one wide signed multiply covers all four variants by choosing the operand extension
   logic [PW-1:0]   w_ma, w_mb, w_prod;
   logic [XLEN-1:0] w_mul_res;

   assign w_ma      = {{(XLEN+2){(r_f3[1:0] != 2'b11) & r_a[XLEN-1]}}, r_a};
   assign w_mb      = {{(XLEN+2){~r_f3[1] & r_b[XLEN-1]}}, r_b};
   assign w_prod    = w_ma * w_mb;
   assign w_mul_res = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

   logic w_unused;
   assign w_unused = ^{i_instr[24:15], i_instr[11:7], w_prod[PW-1:2*XLEN], w_rem_nxt[XLEN], r_f3[2]};

   logic            w_ld_res;
   logic [XLEN-1:0] w_res_nxt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ld_res    = 1'b0;
      w_res_nxt   = '0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (!w_in_f3[2]) begin
                  w_state_nxt = S_MUL;
               end else if (w_bypass) begin
                  w_state_nxt = S_DONE;
                  w_ld_res    = 1'b1;
                  w_res_nxt   = w_byp_res;
               end else begin
                  w_state_nxt = S_DIV;
               end
            end
         end
         S_MUL: begin
            if (r_cnt == CW'(MUL_CYCLES - 1)) begin
               w_state_nxt = S_DONE;
               w_ld_res    = 1'b1;
               w_res_nxt   = w_mul_res;
            end
         end
         S_DIV: begin
            if (r_cnt == CW'(XLEN - 1)) begin
               w_state_nxt = S_DONE;
               w_ld_res    = 1'b1;
               w_res_nxt   = w_div_res;
            end
         end
         S_DONE: begin
            if (i_res_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (i_flush) begin
         w_state_nxt = S_IDLE;
         w_ld_res    = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_f3     <= '0;
         r_quo    <= '0;
         r_rem    <= '0;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         if (w_ld_res) r_result <= w_res_nxt;
         if (!i_flush && (r_state == S_MUL || r_state == S_DIV) && w_state_nxt == r_state)
            r_cnt <= r_cnt + CW'(1);
         else
            r_cnt <= '0;
         if (w_accept) begin
            r_a   <= i_op_a;
            r_b   <= i_op_b;
            r_f3  <= w_in_f3;
            r_rem <= '0;
            r_quo <= w_a_mag_in;
         end else if (r_state == S_DIV && !i_flush) begin
            r_rem <= w_rem_nxt[XLEN-1:0];
            r_quo <= w_quo_nxt;
         end
      end
   end

   assign o_req_ready = (r_state == S_IDLE);
   assign o_busy      = (r_state != S_IDLE);
   assign o_res_valid = (r_state == S_DONE);
   assign o_result    = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized scoreboard bench for muldiv_seq (XLEN=32, MUL_CYCLES=2).
module tb_muldiv_seq;
   localparam int XLEN = 32;
   localparam int MC   = 2;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        req_valid = 1'b0, flush = 1'b0, res_ready = 1'b0;
   logic [31:0] instr = '0, op_a = '0, op_b = '0;
   logic        req_ready, res_valid, busy;
   logic [31:0] result;

   int n_chk = 0, n_err = 0;
   logic [31:0] exp_q[$];

   muldiv_seq #(.XLEN(XLEN), .MUL_CYCLES(MC)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_instr(instr), .i_op_a(op_a), .i_op_b(op_b), .i_flush(flush),
      .o_res_valid(res_valid), .i_res_ready(res_ready), .o_result(result), .o_busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, expv, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] enc(logic [2:0] f3);
      return {7'b0000001, 10'd0, f3, 5'd0, 7'b0110011};
   endfunction

   // reference: plain 64-bit arithmetic from the M-extension definitions
   function automatic logic [31:0] ref_res(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint          ub = longint'({32'h0, b});
      longint unsigned ua = {32'h0, a};
      logic [63:0]     p;
      logic            ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f3)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * {32'h0, b}; return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            p = sa / sb; return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'h0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
      if (!f3[2]) return MC;
      if (b == 0) return 0;
      if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return XLEN;
   endfunction

   // monitor: one pop per result handoff
   always @(negedge clk) begin
      logic [31:0] e;
      if (rst_n && res_valid && res_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL unexpected_result: got %0h with empty scoreboard", result);
         end else begin
            e = exp_q.pop_front();
            chk("result", {32'h0, result}, {32'h0, e});
         end
      end
   end

   task automatic issue(logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                        logic [31:0] expv, int lat, int hold);
      int   n = 0;
      logic bz = 1'b1;
      req_valid = 1'b1; instr = enc(f3); op_a = a; op_b = b; res_ready = 1'b0;
      chk("req_ready_idle", {63'h0, req_ready}, 64'd1);
      exp_q.push_back(expv);
      step();
      req_valid = 1'b0; op_a = $urandom; op_b = $urandom; instr = $urandom;
      while (!res_valid && n < 200) begin
         if (!busy) bz = 1'b0;
         step();
         n++;
      end
      chk("latency", n, lat);
      chk("busy_during_op", {63'h0, bz & busy}, 64'd1);
      for (int k = 0; k < hold; k++) begin
         req_valid = 1'b1; instr = enc(3'($urandom_range(0, 7)));
         chk("hold_valid", {63'h0, res_valid}, 64'd1);
         chk("hold_req_ready", {63'h0, req_ready}, 64'd0);
         chk("hold_result", {32'h0, result}, {32'h0, expv});
         step();
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0; req_valid = 1'b0;
      chk("post_valid", {63'h0, res_valid}, 64'd0);
      chk("post_req_ready", {63'h0, req_ready}, 64'd1);
   endtask

   task automatic rnd_issue(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
      issue(f3, a, b, ref_res(f3, a, b), ref_lat(f3, a, b), $urandom_range(0, 3));
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      #12;
      chk("rst_req_ready", {63'h0, req_ready}, 64'd1);
      chk("rst_res_valid", {63'h0, res_valid}, 64'd0);
      chk("rst_busy", {63'h0, busy}, 64'd0);
      chk("rst_result", {32'h0, result}, 64'd0);
      rst_n = 1'b1;

      // first edge after release accepts
      issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MC, 0);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MC, 1);
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MC, 0);
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MC, 2);
      issue(3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, XLEN, 0);
      issue(3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, XLEN, 1);
      issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0, 0);
      issue(3'd7, 32'd5, 32'd0, 32'd5, 0, 0);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, 5);

      // non-M instructions ignored
      req_valid = 1'b1; instr = {7'b0000000, 10'd0, 3'd0, 5'd0, 7'b0110011};
      step(); step();
      chk("nonm_funct7_busy", {63'h0, busy}, 64'd0);
      instr = {7'b0000001, 10'd0, 3'd4, 5'd0, 7'b0010011};
      step(); step();
      chk("nonm_opcode_busy", {63'h0, busy}, 64'd0);
      chk("nonm_res_valid", {63'h0, res_valid}, 64'd0);

      // flush beats a simultaneous accept
      instr = enc(3'd0); flush = 1'b1;
      step();
      flush = 1'b0; req_valid = 1'b0;
      chk("flush_vs_accept", {63'h0, busy}, 64'd0);

      // flush at cycle 10 of a divide
      req_valid = 1'b1; instr = enc(3'd5); op_a = 32'd1000; op_b = 32'd7;
      step();
      req_valid = 1'b0;
      repeat (9) step();
      chk("div_busy_pre_flush", {63'h0, busy}, 64'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_idle", {63'h0, req_ready}, 64'd1);
      seen = 1'b0;
      repeat (40) begin step(); seen |= res_valid; end
      chk("flush_no_result", {63'h0, seen}, 64'd0);

      // flush while holding a result
      req_valid = 1'b1; instr = enc(3'd5); op_a = 32'd9; op_b = 32'd0;
      step();
      req_valid = 1'b0;
      chk("done_pre_flush", {63'h0, res_valid}, 64'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_done_valid", {63'h0, res_valid}, 64'd0);

      // asynchronous reset mid-divide
      req_valid = 1'b1; instr = enc(3'd4); op_a = 32'h1234_5678; op_b = 32'd13;
      step();
      req_valid = 1'b0;
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      chk("arst_busy", {63'h0, busy}, 64'd0);
      chk("arst_req_ready", {63'h0, req_ready}, 64'd1);
      chk("arst_res_valid", {63'h0, res_valid}, 64'd0);
      chk("arst_result", {32'h0, result}, 64'd0);
      step(); step();
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin step(); seen |= res_valid | busy; end
      chk("arst_no_result", {63'h0, seen}, 64'd0);

      for (int i = 0; i < 60; i++) rnd_issue(3'($urandom_range(0, 7)), pick(), pick());

      chk("scoreboard_empty", exp_q.size(), 64'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter XLEN, default 32: operand/result width; legal values 8..64.
REQ-002 Parameter MUL_CYCLES, default 2: multiply latency in cycles; legal values 1..4.
REQ-003 clk  in  1  rising-edge clock; the only clock.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept; equals (state==IDLE).
REQ-007 instr  in  32  instruction word; opcode [6:0], funct3 [14:12], funct7 [31:25] decoded internally.
REQ-008 op_a  in  XLEN  rs1 value.
REQ-009 op_b  in  XLEN  rs2 value.
REQ-010 flush  in  1  abort any operation in progress.
REQ-011 res_valid  out  1  result present.
REQ-012 res_ready  in  1  consumer accepts result.
REQ-013 result  out  XLEN  registered result.
REQ-014 busy  out  1  state!=IDLE.

Function
REQ-015 Accept when req_valid && req_ready && !flush && opcode==0110011 && funct7==0000001; otherwise no accept.
REQ-016 Non-M instructions with req_valid SHALL be ignored: no state change, no result.
REQ-017 On accept, latch op_a, op_b, funct3; later input changes SHALL not affect the result.
REQ-018 FSM states: IDLE, MUL, DIV, DONE; transitions occur on the rising edge of clk.
REQ-019 funct3 000..011 -> MUL; stay MUL_CYCLES cycles -> DONE; res_valid high after the MUL_CYCLES-th edge following accept.
REQ-020 Multiply: form the 2*XLEN product. MUL = low half, signed x signed. MULH = high half, signed x signed. MULHSU = high half, signed a x unsigned b. MULHU = high half, unsigned x unsigned.
REQ-021 funct3 100..111 -> DIV: radix-2 restoring on magnitudes, one quotient bit per cycle; bit counter width clog2(XLEN+1).
REQ-022 DIV lasts exactly XLEN cycles -> DONE. Signed variants: quotient negated if operand signs differ; remainder takes the sign of the dividend.
REQ-023 Divide by zero SHALL bypass iteration: IDLE->DONE in 1 cycle. DIV/DIVU return all-ones. REM/REMU return op_a.
REQ-024 Signed overflow (op_a = most-negative, op_b = -1) SHALL bypass iteration in 1 cycle. DIV returns op_a. REM returns 0.
REQ-025 DONE: res_valid=1, result stable. Leave to IDLE on the edge where res_ready=1.
REQ-026 req_ready=0 in DONE, so a new request cannot be accepted in the same cycle as the handoff (one-cycle bubble).
REQ-027 flush=1 at any edge SHALL force state IDLE, res_valid=0, counter=0. flush overrides simultaneous accept and res_ready.
REQ-028 result SHALL be updated only on entry to DONE; it holds its value in IDLE.

Reset
REQ-029 rst_n low SHALL immediately, without waiting for clk, force: state IDLE, res_valid 0, result 0, busy 0, counter 0, latched operands 0.
REQ-030 req_ready SHALL be 1 while in reset (state IDLE).
REQ-031 Reset asserted mid-operation SHALL discard the operation; no result is produced after release.
REQ-032 First accept is possible on the first rising edge after rst_n rises.

Verification (XLEN=32, MUL_CYCLES=2)
REQ-033 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, res_valid after 2nd edge post-accept.
REQ-034 Operands 0xFFFFFFFF, 0xFFFFFFFF -> MULHU 0xFFFFFFFE; MULH 0x00000000; MULHSU 0xFFFFFFFF.
REQ-035 DIV 0xFFFFFFEC/3 -> 0xFFFFFFFA; REM -> 0xFFFFFFFE; res_valid after 32nd edge post-accept, busy=1 throughout.
REQ-036 DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of same -> 0; each valid after 1 edge.
REQ-037 res_ready held low 5 cycles in DONE -> result and res_valid held, req_ready=0; res_ready=1 -> IDLE next edge.
REQ-038 flush at cycle 10 of DIV -> IDLE next edge, no res_valid. rst_n low mid-DIV -> all outputs reset without a clock edge.
